// File: rtl/axi_lite_slave_regfile.sv
// AXI-Lite-style responder over a 16 x 8-bit register file; independent read and write FSMs.
// Latency: read data 1 cycle after the AR handshake; B response 1 cycle after the W handshake.
// Backpressure: R_VALID/data_read and B_VALID hold until accepted; no new address is taken meanwhile.
module axi_lite_slave_regfile #(
  parameter logic [7:0]  RESET_VALUE = 8'h00,
  parameter logic [15:0] RO_MASK     = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] read_address,
  input  logic       AR_VALID,
  output logic       AR_READY,
  output logic [7:0] data_read,
  output logic       R_VALID,
  input  logic       R_READY,
  input  logic [3:0] write_address,
  input  logic       AW_VALID,
  output logic       AW_READY,
  input  logic [7:0] data_write,
  input  logic       W_VALID,
  output logic       W_READY,
  output logic       B_VALID,
  input  logic       B_READY
);

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_DATA = 2'd1;

  localparam logic [1:0] WR_ADDR = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  logic [1:0] rd_state;
  logic [1:0] wr_state;
  logic [3:0] awaddr_q;
  logic [7:0] regs [16];
  logic       w_commit;

  // Read-only registers still complete the W/B handshake; only the store is suppressed.
  assign w_commit = (wr_state == WR_DATA) && W_VALID && W_READY && !RO_MASK[awaddr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= RESET_VALUE;
    end else if (w_commit) begin
      regs[awaddr_q] <= data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      AR_READY  <= 1'b0;
      R_VALID   <= 1'b0;
      data_read <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (AR_VALID && AR_READY) begin
            AR_READY  <= 1'b0;
            data_read <= regs[read_address];
            R_VALID   <= 1'b1;
            rd_state  <= RD_DATA;
          end else begin
            AR_READY <= 1'b1;
          end
        end
        RD_DATA: begin
          if (R_VALID && R_READY) begin
            R_VALID   <= 1'b0;
            data_read <= '0;
            AR_READY  <= 1'b1;
            rd_state  <= RD_IDLE;
          end
        end
        default: begin
          rd_state  <= RD_IDLE;
          AR_READY  <= 1'b0;
          R_VALID   <= 1'b0;
          data_read <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_ADDR;
      AW_READY <= 1'b0;
      W_READY  <= 1'b0;
      B_VALID  <= 1'b0;
      awaddr_q <= '0;
    end else begin
      case (wr_state)
        WR_ADDR: begin
          if (AW_VALID && AW_READY) begin
            awaddr_q <= write_address;
            AW_READY <= 1'b0;
            W_READY  <= 1'b1;
            wr_state <= WR_DATA;
          end else begin
            AW_READY <= 1'b1;
            W_READY  <= 1'b0;
          end
        end
        WR_DATA: begin
          if (W_VALID && W_READY) begin
            W_READY  <= 1'b0;
            B_VALID  <= 1'b1;
            wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (B_VALID && B_READY) begin
            B_VALID  <= 1'b0;
            AW_READY <= 1'b1;
            wr_state <= WR_ADDR;
          end
        end
        default: begin
          wr_state <= WR_ADDR;
          AW_READY <= 1'b0;
          W_READY  <= 1'b0;
          B_VALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Bench for axi_lite_slave_regfile: randomized and directed traffic, scoreboard fed by a register-array model.
module tb_axi_lite_slave_regfile;

  localparam logic [7:0]  RV = 8'h00;
  localparam logic [15:0] RO = 16'h0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] read_address = '0;
  logic       AR_VALID = 1'b0;
  logic       AR_READY;
  logic [7:0] data_read;
  logic       R_VALID;
  logic       R_READY = 1'b0;
  logic [3:0] write_address = '0;
  logic       AW_VALID = 1'b0;
  logic       AW_READY;
  logic [7:0] data_write = '0;
  logic       W_VALID = 1'b0;
  logic       W_READY;
  logic       B_VALID;
  logic       B_READY = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  axi_lite_slave_regfile #(.RESET_VALUE(RV), .RO_MASK(RO)) dut (
    .clk(clk), .rst(rst),
    .read_address(read_address), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .data_read(data_read), .R_VALID(R_VALID), .R_READY(R_READY),
    .write_address(write_address), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .data_write(data_write), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: register array updated by the rules, expected reads/responses queued in order.
  logic [7:0] model [16];
  logic [7:0] rq [$];
  logic [3:0] bq [$];
  logic [3:0] wa;
  logic       last_rst = 1'b1, last2_rst = 1'b1;
  logic       exp_rv = 1'b0, exp_bv = 1'b0, r_hold = 1'b0, b_hold = 1'b0;
  logic [7:0] held_r;

  // Monitor: at each falling edge, check what the last rising edge produced,
  // then predict the handshakes the next rising edge will complete.
  initial begin
    forever begin
      @(negedge clk);
      if (last_rst) begin
        chk("reset_outputs", {AR_READY, R_VALID, data_read, AW_READY, W_READY, B_VALID}, 32'h0);
      end else begin
        if (last2_rst) chk("ready_after_reset", {AR_READY, AW_READY}, 2'b11);
        if (exp_rv) chk("r_latency", R_VALID, 1);
        if (exp_bv) chk("b_latency", B_VALID, 1);
        if (r_hold) chk("r_stable", {R_VALID, AR_READY, data_read}, {1'b1, 1'b0, held_r});
        if (b_hold) chk("b_stable", {B_VALID, AW_READY, W_READY}, 3'b100);
        if (R_VALID) chk("r_expected", rq.size() > 0, 1);
        if (B_VALID) chk("b_expected", bq.size() > 0, 1);
      end
      last2_rst = last_rst;
      last_rst  = rst;
      exp_rv = 1'b0; exp_bv = 1'b0; r_hold = 1'b0; b_hold = 1'b0;
      if (rst) begin
        for (int i = 0; i < 16; i++) model[i] = RV;
        rq.delete();
        bq.delete();
      end else begin
        if (R_VALID && R_READY && rq.size() > 0) chk("read_data", data_read, rq.pop_front());
        r_hold = R_VALID && !R_READY;
        held_r = data_read;
        if (B_VALID && B_READY && bq.size() > 0) void'(bq.pop_front());
        b_hold = B_VALID && !B_READY;
        // Read sampled before the write is applied: same-edge collision returns the old value.
        if (AR_VALID && AR_READY) begin
          rq.push_back(model[read_address]);
          exp_rv = 1'b1;
        end
        if (W_VALID && W_READY) begin
          if (!RO[wa]) model[wa] = data_write;
          bq.push_back(wa);
          exp_bv = 1'b1;
        end
        if (AW_VALID && AW_READY) wa = write_address;
      end
    end
  end

  task automatic wait_for(input int sel, input string nm);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      case (sel)
        0: hit = AR_READY;
        1: hit = R_VALID;
        2: hit = AW_READY;
        3: hit = W_READY;
        default: hit = B_VALID;
      endcase
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got no handshake, required one within 100 cycles", nm);
    end
  endtask

  task automatic rd(input logic [3:0] a, input int stall);
    @(posedge clk); #1;
    read_address = a; AR_VALID = 1'b1;
    wait_for(0, "ar");
    @(posedge clk); #1;
    AR_VALID = 1'b0; read_address = 4'($urandom);
    wait_for(1, "r");
    repeat (stall) @(negedge clk);
    @(posedge clk); #1; R_READY = 1'b1;
    @(posedge clk); #1; R_READY = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input int stall);
    @(posedge clk); #1;
    write_address = a; data_write = d; AW_VALID = 1'b1;
    W_VALID = 1'($urandom_range(0, 1));   // early W must be ignored until the address is taken
    wait_for(2, "aw");
    @(posedge clk); #1;
    AW_VALID = 1'b0; write_address = 4'($urandom); W_VALID = 1'b1;
    wait_for(3, "w");
    @(posedge clk); #1;
    W_VALID = 1'b0; data_write = 8'($urandom);
    wait_for(4, "b");
    repeat (stall) @(negedge clk);
    @(posedge clk); #1; B_READY = 1'b1;
    @(posedge clk); #1; B_READY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) rd(4'(i), 0);

    wr(4'd3, 8'hA5, 0);
    rd(4'd3, 0);
    rd(4'd3, 5);
    wr(4'd3, 8'h5A, 5);
    rd(4'd3, 0);

    wr(4'd0, 8'h3C, 0);
    rd(4'd0, 0);
    wr(4'd15, 8'hF0, 1);
    rd(4'd15, 2);

    // Collision on register 7: AR and W handshakes on the same edge.
    wr(4'd7, 8'h11, 0);
    @(posedge clk); #1;
    write_address = 4'd7; AW_VALID = 1'b1;
    wait_for(2, "aw_col");
    @(posedge clk); #1;
    AW_VALID = 1'b0; W_VALID = 1'b1; data_write = 8'h22;
    AR_VALID = 1'b1; read_address = 4'd7;
    @(posedge clk); #1;
    W_VALID = 1'b0; AR_VALID = 1'b0; R_READY = 1'b1; B_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1 R_READY = 1'b0; B_READY = 1'b0;
    rd(4'd7, 0);

    fork
      for (int k = 0; k < 25; k++) wr(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3));
      for (int k = 0; k < 30; k++) rd(4'($urandom_range(0, 15)), $urandom_range(0, 3));
    join

    // Reset while in WR_DATA with 8'hFF pending for register 5.
    wr(4'd5, 8'h77, 0);
    @(posedge clk); #1;
    write_address = 4'd5; AW_VALID = 1'b1;
    wait_for(2, "aw_rst");
    @(posedge clk); #1;
    AW_VALID = 1'b0; W_VALID = 1'b1; data_write = 8'hFF; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; W_VALID = 1'b0;
    repeat (4) @(posedge clk);
    rd(4'd5, 0);
    rd(4'd7, 0);

    repeat (5) @(posedge clk);
    chk("drain", rq.size() + bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
